uart_tx_scheduler: RTL and testbench

Two-requester frame scheduler for the UART transmitter. It arbitrates round-robin between requester A and requester B. Each requester sends a 2-byte frame: a code byte, then a value byte. The scheduler drives the transmitter's byte handshake: it holds `has_data` until the transmitter reports busy, waits for completion, then sends the next byte. A timeout protects against a hung transmitter.

---
 rtl/uart_tx_scheduler.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin two-requester scheduler feeding 2-byte frames (code, value) to a UART transmitter.
// Latency: req in IDLE at t -> tx_has_data at t+1; final tx_done rise at w -> ack at w+1, IDLE at w+2.
// Backpressure: req is a held level; the loser waits in IDLE; tx_has_data held until tx_busy or timeout.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   req_x, code_x, value_x       requester x (a/b) frame request and payload, sampled at grant
//   ack_x                        1-cycle pulse when requester x's frame completes
//   err                          1-cycle pulse on timeout abort, owner given by grant
//   busy, grant                  frame in flight; current/last owner (0 = A, 1 = B)
//   tx_has_data, tx_data         byte handshake towards the transmitter
//   tx_busy, tx_done             transmitter status (tx_done high 2 cycles per byte)
module uart_tx_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_a,
    input  logic [7:0] code_a,
    input  logic [7:0] value_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [7:0] code_b,
    input  logic [7:0] value_b,
    output logic       ack_b,
    output logic       err,
    output logic       busy,
    output logic       grant,
    output logic       tx_has_data,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_done
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_ACK, S_ABORT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  value_q, value_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_q, last_d;       // last served requester, 1 = B
    logic        done_q;               // registered tx_done for edge detect
    logic        has_data_q, has_data_d;
    logic        ack_a_q, ack_a_d;
    logic        ack_b_q, ack_b_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        grant_q, grant_d;
    logic        pick_b;
    logic        done_rise;

    assign done_rise = tx_done & ~done_q;
    // Tie goes to whoever was not served last; a lone request simply wins.
    assign pick_b    = (req_a & req_b) ? ~last_q : req_b;

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        has_data_d = has_data_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q;
        grant_d    = grant_q;

        case (state_q)
            S_IDLE: begin
                if (req_a | req_b) begin
                    grant_d    = pick_b;
                    value_d    = pick_b ? value_b : value_a;
                    data_d     = pick_b ? code_b : code_a;
                    busy_d     = 1'b1;
                    has_data_d = 1'b1;
                    cnt_d      = 16'd0;
                    state_d    = S_REQ0;
                end
            end
            S_REQ0, S_REQ1: begin
                if (tx_busy) begin
                    has_data_d = 1'b0;
                    state_d    = (state_q == S_REQ0) ? S_WAIT0 : S_WAIT1;
                end else if (cnt_q == TIMEOUT_LIM) begin
                    has_data_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_ABORT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT0: begin
                // Only the rising edge advances; the second tx_done cycle is ignored.
                if (done_rise) begin
                    data_d     = value_q;
                    has_data_d = 1'b1;
                    cnt_d      = 16'd0;
                    state_d    = S_REQ1;
                end
            end
            S_WAIT1: begin
                if (done_rise) begin
                    ack_a_d = ~grant_q;
                    ack_b_d = grant_q;
                    state_d = S_ACK;
                end
            end
            S_ACK, S_ABORT: begin
                last_d  = grant_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            value_q    <= 8'd0;
            data_q     <= 8'd0;
            cnt_q      <= 16'd0;
            last_q     <= 1'b1;
            done_q     <= 1'b0;
            has_data_q <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            done_q     <= tx_done;
            has_data_q <= has_data_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
        end
    end

    assign tx_has_data = has_data_q;
    assign tx_data     = data_q;
    assign ack_a       = ack_a_q;
    assign ack_b       = ack_b_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign grant       = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: transmitter model, two requester drivers, scoreboard monitor.
// Latency: drivers/transmitter act 1 time unit after the edge, monitor samples 2 units after.
// Backpressure: the transmitter model accepts a byte only when idle; a stuck mode never accepts.
module tb_uart_tx_scheduler;

    localparam int TO = 8;

    logic       clock, reset;
    logic       req_a, req_b, ack_a, ack_b, err, busy, grant;
    logic [7:0] code_a, value_a, code_b, value_b, tx_data;
    logic       tx_has_data, tx_busy, tx_done;

    uart_tx_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .code_a(code_a), .value_a(value_a), .ack_a(ack_a),
        .req_b(req_b), .code_b(code_b), .value_b(value_b), .ack_b(ack_b),
        .err(err), .busy(busy), .grant(grant),
        .tx_has_data(tx_has_data), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done)
    );

    typedef struct {
        logic [7:0] code;
        logic [7:0] value;
        bit         is_err;
    } frame_t;

    frame_t     exp_a[$];
    frame_t     exp_b[$];
    logic [7:0] line_q[$];     // bytes the transmitter put on the line for the current frame
    int         checks;
    int         errors;
    bit         stuck;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    // Transmitter: idle -> (has_data) -> busy for 2..5 cycles -> done for 2 cycles -> idle.
    initial begin
        int         st;
        int         cnt;
        logic [7:0] cur;
        bit         rst_seen;
        st = 0; cnt = 0; cur = 8'd0; rst_seen = 1'b0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(posedge clock); #1;
            tx_busy = (st == 1);
            tx_done = (st == 2) || (st == 3);
            if (reset) rst_seen = 1'b1;
            case (st)
                0: if (tx_has_data && !stuck) begin
                    line_q.push_back(tx_data);
                    cur      = tx_data;
                    cnt      = $urandom_range(2, 5);
                    rst_seen = 1'b0;
                    st       = 1;
                end
                1: begin
                    if (!rst_seen) chk("line_data_stable", tx_data, cur);
                    cnt--;
                    if (cnt == 0) st = 2;
                end
                2: st = 3;
                default: st = 0;
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        int         cyc, hd_rise;
        logic       p_reset, p_req_a, p_req_b, p_busy, p_hd, p_txbusy, p_done, pp_done;
        logic       post, post_prev, m_last, eg, drise;
        logic [7:0] p_code_a, p_code_b, p_value_a, p_value_b, p_txdata, f_val;
        frame_t     e;
        cyc = 0; hd_rise = 0;
        p_reset = 1'b1; p_req_a = 1'b0; p_req_b = 1'b0; p_busy = 1'b0; p_hd = 1'b0;
        p_txbusy = 1'b0; p_done = 1'b0; pp_done = 1'b0; post = 1'b0; post_prev = 1'b0;
        m_last = 1'b1; eg = 1'b0;
        p_code_a = 8'd0; p_code_b = 8'd0; p_value_a = 8'd0; p_value_b = 8'd0;
        p_txdata = 8'd0; f_val = 8'd0;
        forever begin
            @(posedge clock); #2;
            cyc++;
            post  = 1'b0;
            drise = p_done && !pp_done;
            if (p_reset) begin
                chk("reset_outputs", {tx_has_data, tx_data, ack_a, ack_b, err, busy, grant}, 0);
                exp_a.delete();
                exp_b.delete();
                line_q.delete();
                m_last = 1'b1;
            end else if (!p_busy) begin
                chk("grant_on_request", busy, p_req_a | p_req_b);
                chk("no_pulse_in_idle", {ack_a, ack_b, err}, 0);
                if (busy) begin
                    eg = (p_req_a && p_req_b) ? !m_last : p_req_b;
                    chk("arbitration", grant, eg);
                    chk("grant_has_data", tx_has_data, 1);
                    chk("grant_code", tx_data, eg ? p_code_b : p_code_a);
                    f_val   = eg ? p_value_b : p_value_a;
                    hd_rise = cyc;
                end
            end else begin
                if (drise && line_q.size() == 1) begin
                    chk("value_has_data", tx_has_data, 1);
                    chk("value_byte", tx_data, f_val);
                end else begin
                    chk("tx_data_hold", tx_data, p_txdata);
                    if (drise) chk("ack_after_last_done", grant ? ack_b : ack_a, 1);
                end
                if (p_hd && p_txbusy) chk("has_data_drop", tx_has_data, 0);
                if (ack_a || ack_b) begin
                    chk("ack_owner", {ack_b, ack_a}, grant ? 2 : 1);
                    chk("ack_timing", drise, 1);
                    chk("ack_expected", grant ? exp_b.size() > 0 : exp_a.size() > 0, 1);
                    if (grant ? exp_b.size() > 0 : exp_a.size() > 0) begin
                        e = grant ? exp_b.pop_front() : exp_a.pop_front();
                        chk("ack_not_error_frame", e.is_err, 0);
                        chk("frame_len", line_q.size(), 2);
                        if (line_q.size() == 2) begin
                            chk("line_byte0", line_q[0], e.code);
                            chk("line_byte1", line_q[1], e.value);
                        end
                    end
                    line_q.delete();
                    m_last = grant;
                    post   = 1'b1;
                end
                if (err) begin
                    chk("err_timing", cyc, hd_rise + TO + 1);
                    chk("err_has_data", tx_has_data, 0);
                    chk("err_no_ack", ack_a | ack_b, 0);
                    chk("err_expected", grant ? exp_b.size() > 0 : exp_a.size() > 0, 1);
                    if (grant ? exp_b.size() > 0 : exp_a.size() > 0) begin
                        e = grant ? exp_b.pop_front() : exp_a.pop_front();
                        chk("err_on_stuck_frame", e.is_err, 1);
                    end
                    chk("err_no_line_bytes", line_q.size(), 0);
                    line_q.delete();
                    m_last = grant;
                    post   = 1'b1;
                end
                if (post_prev) chk("idle_after_end", {busy, ack_a, ack_b, err}, 0);
            end
            post_prev = post;
            pp_done   = p_done;
            p_done    = tx_done;
            p_reset   = reset;
            p_req_a   = req_a;
            p_req_b   = req_b;
            p_code_a  = code_a;
            p_code_b  = code_b;
            p_value_a = value_a;
            p_value_b = value_b;
            p_busy    = busy;
            p_hd      = tx_has_data;
            p_txbusy  = tx_busy;
            p_txdata  = tx_data;
        end
    end

    // Requester driver: issues nframes frames, either holding req across frames or
    // dropping it for a random gap, and waits (bounded) for its own ack or err.
    task automatic run_req(input bit who, input int nframes, input bit rnd,
                           input logic [7:0] c0, input logic [7:0] v0);
        frame_t f;
        bit     got;
        for (int i = 0; i < nframes; i++) begin
            f.code   = rnd ? 8'($urandom_range(0, 255)) : (c0 ^ 8'(i));
            f.value  = rnd ? 8'($urandom_range(0, 255)) : (v0 ^ 8'(i));
            f.is_err = stuck;
            if (rnd && $urandom_range(0, 1) == 1) begin
                if (who) req_b = 1'b0; else req_a = 1'b0;
                repeat ($urandom_range(1, 6)) @(posedge clock);
                #1;
            end
            if (who) begin
                code_b = f.code; value_b = f.value; req_b = 1'b1; exp_b.push_back(f);
            end else begin
                code_a = f.code; value_a = f.value; req_a = 1'b1; exp_a.push_back(f);
            end
            got = 1'b0;
            for (int n = 0; n < 400 && !got; n++) begin
                @(posedge clock); #1;
                got = who ? (ack_b || (err && grant)) : (ack_a || (err && !grant));
            end
            chk(who ? "frame_finish_b" : "frame_finish_a", got, 1);
        end
        if (who) req_b = 1'b0; else req_a = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    // Reset while the value byte is being transmitted (scheduler in WAIT1).
    task automatic reset_mid_frame();
        frame_t f;
        bit     hit;
        f.code = 8'hC3; f.value = 8'h3C; f.is_err = 1'b0;
        code_a = f.code; value_a = f.value; req_a = 1'b1;
        exp_a.push_back(f);
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(posedge clock); #3;
            hit = (line_q.size() == 2) && tx_busy && !tx_has_data && busy;
        end
        chk("reached_wait1", hit, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        req_a = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0; stuck = 1'b0;
        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        code_a = 8'd0; value_a = 8'd0; code_b = 8'd0; value_b = 8'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        // Single frame from A.
        run_req(1'b0, 1, 1'b0, 8'h41, 8'h7F);
        repeat (4) @(posedge clock);
        #1;

        // Tie right after reset, then both held for 4 frames each.
        do_reset();
        fork
            run_req(1'b0, 4, 1'b0, 8'hA0, 8'h10);
            run_req(1'b1, 4, 1'b0, 8'hB0, 8'h20);
        join
        repeat (10) @(posedge clock);
        #1;

        // Hung transmitter, then a normal frame.
        stuck = 1'b1;
        run_req(1'b0, 1, 1'b0, 8'h55, 8'h66);
        stuck = 1'b0;
        run_req(1'b0, 1, 1'b0, 8'h12, 8'h34);
        repeat (4) @(posedge clock);
        #1;

        reset_mid_frame();
        run_req(1'b1, 1, 1'b0, 8'h9A, 8'hBC);

        // Randomized concurrent traffic.
        fork
            run_req(1'b0, 15, 1'b1, 8'h00, 8'h00);
            run_req(1'b1, 15, 1'b1, 8'h00, 8'h00);
        join
        repeat (20) @(posedge clock);
        chk("scoreboard_a_empty", exp_a.size(), 0);
        chk("scoreboard_b_empty", exp_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
